// File: rtl/icache.sv
// +--------------------------------------------------------------------------+
// | Module   : icache                                                        |
// | Purpose  : Direct-mapped read-only instruction cache with word-by-word   |
// |            line refill from the memory controller.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module icache #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_from_if,
    input  logic [31:0] pc_from_if,
    input  logic        rollback,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_valid,
    input  logic [31:0] mc_data
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int TAG_LSB   = 2 + WORD_BITS + INDEX_BITS;
    localparam int TAG_BITS  = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    state_t                 state_q, state_d;
    logic [31:2]            req_pc_q, req_pc_d;
    logic [WORD_BITS-1:0]   cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic                   mc_req_q, mc_req_d;
    logic [31:0]            mc_addr_q, mc_addr_d;
    logic [31:0]            instr_out_q, instr_out_d;
    logic                   resp_q, resp_d;
    logic [LINES-1:0]       valid_q, valid_d;
    line_t                  line_buf_q, line_buf_d;

    logic [TAG_BITS-1:0]    tag_mem [LINES];
    line_t                  data_mem [LINES];

    logic [TAG_BITS-1:0]    pc_tag;
    logic [INDEX_BITS-1:0]  pc_idx;
    logic [WORD_BITS-1:0]   pc_word;
    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [WORD_BITS-1:0]   req_word;
    logic                   pc_hit;
    logic                   last_beat;
    logic                   install;
    line_t                  fill_line;
    logic                   unused_pc_bits;

    assign pc_tag   = pc_from_if[31:TAG_LSB];
    assign pc_idx   = pc_from_if[2+WORD_BITS +: INDEX_BITS];
    assign pc_word  = pc_from_if[2 +: WORD_BITS];
    assign req_tag  = req_pc_q[31:TAG_LSB];
    assign req_idx  = req_pc_q[2+WORD_BITS +: INDEX_BITS];
    assign req_word = req_pc_q[2 +: WORD_BITS];

    assign unused_pc_bits = ^pc_from_if[1:0];

    assign pc_hit    = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign last_beat = (cnt_q == WORD_BITS'(LINE_WORDS - 1));
    assign install   = rdy && (state_q == S_REFILL) && mc_valid && last_beat;

    // The final beat's word never passes through the line buffer, so the
    // installed line and the returned instruction both come from fill_line.
    always_comb begin
        fill_line        = line_buf_q;
        fill_line[cnt_q] = mc_data;
    end

    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        mc_req_d    = mc_req_q;
        mc_addr_d   = mc_addr_q;
        instr_out_d = instr_out_q;
        resp_d      = resp_q;
        valid_d     = valid_q;
        line_buf_d  = line_buf_q;

        if (rdy) begin
            resp_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    drop_d = 1'b0;
                    if (req_from_if && !rollback) begin
                        req_pc_d = pc_from_if[31:2];
                        if (pc_hit) begin
                            instr_out_d = data_mem[pc_idx][pc_word];
                            resp_d      = 1'b1;
                            state_d     = S_RESP;
                        end else begin
                            mc_addr_d = {pc_from_if[31:2+WORD_BITS], {(WORD_BITS+2){1'b0}}};
                            mc_req_d  = 1'b1;
                            cnt_d     = '0;
                            state_d   = S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (rollback) begin
                        drop_d = 1'b1;
                    end
                    if (mc_valid) begin
                        line_buf_d = fill_line;
                        cnt_d      = cnt_q + WORD_BITS'(1);
                        mc_addr_d  = mc_addr_q + 32'd4;
                        if (last_beat) begin
                            mc_req_d         = 1'b0;
                            valid_d[req_idx] = 1'b1;
                            instr_out_d      = fill_line[req_word];
                            if (drop_q || rollback) begin
                                drop_d  = 1'b0;
                                state_d = S_IDLE;
                            end else begin
                                resp_d  = 1'b1;
                                state_d = S_RESP;
                            end
                        end
                    end
                end
                S_RESP: begin
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_pc_q    <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= '0;
            instr_out_q <= '0;
            resp_q      <= 1'b0;
            valid_q     <= '0;
            line_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            mc_req_q    <= mc_req_d;
            mc_addr_q   <= mc_addr_d;
            instr_out_q <= instr_out_d;
            resp_q      <= resp_d;
            valid_q     <= valid_d;
            line_buf_q  <= line_buf_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= fill_line;
        end
    end

    assign instr_valid = resp_q && !rollback;
    assign instr_out   = instr_out_q;
    assign mc_req      = mc_req_q;
    assign mc_addr     = mc_addr_q;

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache answering fetch requests from the instruction fetcher and refilling misses from the memory controller. It holds the fetcher's PC, returns one 32-bit instruction per request with a one-cycle `instr_valid` pulse, and fetches whole lines word-by-word on a miss. It sits between the IF stage and the memory controller, on the fetcher's `rdy_2icache`/`pc_2icache`/`instr_valid`/`instr_from_icache` interface.

## Interface
- `INDEX_BITS`, 6: line index width; 64 lines.
- `LINE_WORDS`, 4: 32-bit words per line, power of two; 16-byte lines.
- Address split: [1:0] byte offset, ignored; next log2(LINE_WORDS) bits are the word; next INDEX_BITS bits are the index; the rest is the tag (22 bits at defaults).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `rdy`  in  1  global enable; 0 freezes all state and outputs.
- `req_from_if`  in  1  fetcher requests the instruction at `pc_from_if`.
- `pc_from_if`  in  32  fetch address; held stable by the fetcher until `instr_valid`.
- `rollback`  in  1  cancels any outstanding response.
- `instr_valid`  out  1  registered; one-cycle pulse, `instr_out` valid.
- `instr_out`  out  32  registered instruction.
- `mc_req`  out  1  refill word request, held until `mc_valid`.
- `mc_addr`  out  32  word-aligned refill address.
- `mc_valid`  in  1  memory controller returns `mc_data` for `mc_addr` this cycle.
- `mc_data`  in  32  refill word.

## Operation
- Storage: per line, one valid bit, a tag and LINE_WORDS data words. Reset clears all valid bits. Data and tags are not reset.
- FSM states: IDLE, REFILL, RESP. Reset state: IDLE.
- IDLE: `req_from_if` && !`rollback` latches the PC into `req_pc`.
  - On a hit (valid && tag match), load `instr_out` with the addressed word and go to RESP.
  - On a miss, set `mc_addr` = {tag, index, word 0, 2'b00}, set `mc_req`=1, clear the word counter, and go to REFILL.
- REFILL: each cycle with `mc_valid`=1, write `mc_data` into the line buffer at the counter position, increment the counter, and add 4 to `mc_addr`.
  - On the last beat (counter == LINE_WORDS-1): deassert `mc_req`, write the tag, set the valid bit and install the line. Load `instr_out` with word `req_pc`'s word field, which may be `mc_data` of this beat. Go to RESP, or to IDLE if `drop` is set.
  - The line is always installed once started; a refill is never aborted except by reset.
- RESP: `instr_valid`=1 for exactly this cycle. Next state is IDLE. No request is accepted in RESP, because the fetcher's PC advances only at the end of this cycle.
- Rollback rules:
  - IDLE: the request sampled that cycle is ignored.
  - REFILL: set `drop`; the refill completes and the response is suppressed.
  - RESP: `instr_valid` is forced to 0 that cycle.
  - `drop` clears on entering IDLE.
- `rdy`=0: no state, counter, array or output register changes; `mc_valid` is ignored. The memory controller is frozen by the same `rdy`.
- Arithmetic: `mc_addr` increments mod 2^32. The counter is log2(LINE_WORDS) bits. The tag compare uses the full tag width.

## Timing
- Reset values: `instr_valid`=0, `instr_out`=0, `mc_req`=0, `mc_addr`=0, state IDLE, `drop`=0.
- Hit: request sampled in cycle N; `instr_valid`=1 in cycle N+1; the next request is accepted in cycle N+2. Peak throughput is 1 instruction per 2 cycles.
- Miss: `mc_req`=1 from cycle N+1; `instr_valid`=1 the cycle after the final `mc_valid` beat. With a 1-cycle memory, the response is at N+1+LINE_WORDS.
- `rdy`=0 cycles stretch every latency by exactly their count.
- `rst` going low mid-refill: immediate abort. Valid bits are cleared and `mc_req` drops asynchronously.

## Test plan
- Cold miss: after reset, request PC 0x00000000 with a memory returning words 0x11,0x22,0x33,0x44 on consecutive cycles -> `mc_addr` steps 0x0,0x4,0x8,0xC; `instr_valid`=1 with `instr_out`=0x11 one cycle after the 4th beat.
- Hit: next request PC 0x00000008 -> `instr_valid` the following cycle with 0x33, `mc_req` stays 0; a request held during RESP produces no second pulse.
- Conflict eviction: PC 0x00000000, then 0x00000400 (same index, different tag), then 0x00000000 again -> three refills, correct data each time.
- Rollback mid-refill: `rollback`=1 on the 2nd beat -> refill completes, no `instr_valid`; a re-request of the same PC then hits with 1-cycle latency.
- Stall: `rdy`=0 for 3 cycles during RESP and during REFILL -> outputs frozen, `instr_valid` still a single pulse, all data correct.
- Reset mid-refill: `rst`=0 after 2 beats -> `mc_req`=0 immediately; a re-request misses and refetches the full line.
